// File: rtl/sum_pkg.sv
// Shared types and sizing for the sum_feeder operand streamer.
package sum_pkg;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int DATA_W  = 16;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_STREAM,
    ST_TERM,
    ST_WAIT,
    ST_REPORT
  } state_t;

  // States in which the summer may flag an error.
  function automatic logic is_active(input state_t s);
    return (s == ST_GO) || (s == ST_STREAM) || (s == ST_TERM) || (s == ST_WAIT);
  endfunction
endpackage

// File: rtl/sum_feeder_buf.sv
// Operand store: DEPTH x DATA_W registers filled in write order, read by index.
module sum_feeder_buf
  import sum_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;

  // Zero is the summer's terminator, so it can never be a stored operand.
  assign w_wr = wr_en && (wr_data != '0) && (r_count != CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_wr) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count  <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[rd_idx];
  assign count   = r_count;
endmodule

// File: rtl/sum_feeder.sv
// Streams buffered operands to a handshake-driven summer and captures its result.
module sum_feeder
  import sum_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              gon,
  output logic [DATA_W-1:0] ina,
  input  logic              done,
  input  logic              err,
  input  logic [DATA_W-1:0] sum,
  output logic              busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_err,
  output logic              res_timeout,
  output logic [CNT_W-1:0]  count
);
  state_t            r_state;
  state_t            w_next;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] w_rd_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_start_ok;
  logic              w_last;
  logic              w_err_hit;
  logic              w_done_hit;
  logic              w_tmo_hit;

  sum_feeder_buf u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en && (r_state == ST_IDLE)),
    .wr_data (wr_data),
    .clr     (r_state == ST_REPORT),
    .rd_idx  (r_rd_ptr),
    .rd_data (w_rd_data),
    .count   (w_count)
  );

  assign w_start_ok = start && (r_state == ST_IDLE) && (w_count != '0);
  assign w_last     = ({1'b0, r_rd_ptr} == (w_count - CNT_W'(1)));
  // Priority: error over done over timeout.
  assign w_err_hit  = err && is_active(r_state);
  assign w_done_hit = !err && !done && ((r_state == ST_TERM) || (r_state == ST_WAIT));
  assign w_tmo_hit  = !err && done && (r_state == ST_WAIT) && (r_tmo == TMO_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_GO;
      ST_GO:     if (w_err_hit) w_next = ST_REPORT;
                 else if (w_count > CNT_W'(1)) w_next = ST_STREAM;
                 else w_next = ST_TERM;
      ST_STREAM: if (w_err_hit) w_next = ST_REPORT;
                 else if (w_last) w_next = ST_TERM;
      ST_TERM:   if (w_err_hit || w_done_hit) w_next = ST_REPORT;
                 else w_next = ST_WAIT;
      ST_WAIT:   if (w_err_hit || w_done_hit || w_tmo_hit) w_next = ST_REPORT;
      ST_REPORT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // TERM counts as the first timeout cycle, so REPORT lands TIMEOUT cycles after TERM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
      r_tmo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   r_rd_ptr <= '0;
        ST_GO:     begin
                     r_rd_ptr <= PTR_W'(1);
                     r_tmo    <= '0;
                   end
        ST_STREAM: r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        ST_TERM:   r_tmo    <= TMO_W'(1);
        ST_WAIT:   r_tmo    <= r_tmo + TMO_W'(1);
        default:   r_rd_ptr <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_sum     <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
    end else if (w_start_ok) begin
      res_sum     <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
    end else if (w_err_hit) begin
      res_sum     <= '0;
      res_err     <= 1'b1;
    end else if (w_done_hit) begin
      res_sum     <= sum;
    end else if (w_tmo_hit) begin
      res_sum     <= '0;
      res_timeout <= 1'b1;
    end
  end

  always_comb begin
    gon = 1'b1;
    ina = '0;
    case (r_state)
      ST_GO: begin
        gon = 1'b0;
        ina = w_rd_data;
      end
      ST_STREAM: ina = w_rd_data;
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign res_valid = (r_state == ST_REPORT);
  assign count     = w_count;
endmodule

// File: doc/sum_feeder.md
SUM_FEEDER -- requirements
Module: sum_feeder

Interface
REQ-001 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-003 Port wr_en, input, 1: buffer write strobe, active-high.
REQ-004 Port wr_data, input, 16: operand to buffer.
REQ-005 Port start, input, 1: one-cycle request to stream buffer contents to the summer.
REQ-006 Port gon, output, 1: active-low go to summer; low marks first operand cycle.
REQ-007 Port ina, output, 16: operand bus to summer; value 0 terminates a sequence.
REQ-008 Port done, input, 1: active-low sequence-complete from summer.
REQ-009 Port err, input, 1: active-high overflow/error from summer.
REQ-010 Port sum, input, 16: summer result.
REQ-011 Ports busy (1), res_valid (1), res_sum (16), res_err (1), res_timeout (1), count (4), all outputs: transaction in progress; one-cycle result strobe; captured sum; summer error seen; done never arrived; operands buffered (0..8).

Function
REQ-012 Buffer SHALL hold DEPTH=8 operands in write order.
REQ-013 wr_en SHALL be ignored when wr_data==0, count==8 or busy==1; otherwise store and increment count the next cycle.
REQ-014 start SHALL be ignored when busy==1 or count==0.
REQ-015 States SHALL be IDLE, GO, STREAM, TERM, WAIT, REPORT.
REQ-016 IDLE: gon=1, ina=0, busy=0; accepted start -> GO.
REQ-017 GO (exactly one cycle): gon=0, ina=buf[0]; -> STREAM if count>1, else TERM.
REQ-018 STREAM: gon=1, ina=buf[rd_ptr], rd_ptr increments each cycle; after buf[count-1] -> TERM.
REQ-019 TERM (one cycle): gon=1, ina=0 (terminator).
REQ-020 TERM/WAIT: done==0 sampled -> capture sum into res_sum, -> REPORT.
REQ-021 err==1 sampled in any of GO, STREAM, TERM, WAIT SHALL set res_err; streaming stops, ina=0 and gon=1 driven, -> REPORT next cycle; res_sum=0.
REQ-022 WAIT: TIMEOUT=16 cycles counted from TERM without done==0 SHALL set res_timeout, res_sum=0, -> REPORT.
REQ-023 If done==0 and err==1 in the same cycle, err SHALL take priority.
REQ-024 REPORT (one cycle): res_valid=1, count cleared to 0, -> IDLE; res_sum/res_err/res_timeout held until the next accepted start, cleared on that start.
REQ-025 busy=1 in every state except IDLE.
REQ-026 Stream latency: accepted start to TERM = count+1 cycles.

Reset
REQ-027 rstn low SHALL immediately force IDLE, gon=1, ina=0, count=0, rd_ptr=0, timeout counter=0, busy=0, res_valid=0, res_sum=0, res_err=0, res_timeout=0.
REQ-028 Reset mid-transaction SHALL discard buffered operands; no res_valid pulse for the aborted transaction.

Structure
REQ-029 Package sum_pkg SHALL hold: state enum type, DEPTH=8, TIMEOUT=16, data width 16.
REQ-030 Operand storage SHALL be sub-module sum_feeder_buf (8x16 registers, write pointer, count, indexed read); FSM and timeout counter in sum_feeder.

Verification
REQ-031 Write 3,5,7; start; summer model returns done=0 with sum=15 in TERM -> gon low 1 cycle with ina=3, ina 5,7,0, res_valid with res_sum=15, res_err=0.
REQ-032 Write 0x8000,0x8000; start; model asserts err=1 in the cycle after ina=0x8000 (2nd) -> res_valid, res_err=1, res_sum=0.
REQ-033 Write 9 non-zero values plus a 0 -> count=8; 9th and zero writes dropped; start streams exactly 8 operands.
REQ-034 Write 4; start; model never asserts done -> res_valid 16 cycles after TERM, res_timeout=1.
REQ-035 Write 1,2; start; drop rstn during STREAM -> gon=1, ina=0, count=0 immediately, no res_valid; later start ignored (count 0).
REQ-036 start with count=0, and start/wr_en while busy -> no state change, busy stays 0 / buffer unchanged.
